armleocpu_dmi_target: RTL

- DMI responder: the Debug Module end of the DMI bus driven by the JTAG DTM.
- Accepts one DMI request at a time, decodes a fixed subset of RISC-V Debug 0.13 DM registers, and returns exactly one response per request.
- Drives halt/resume/ndmreset to the hart.
- Runs an abstract register-access command through a valid/ready handshake to the core's debug port.
- Sits between the DTM and the CPU core in the debug subsystem.

---
 rtl/armleocpu_dmi_target.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/armleocpu_dmi_target.sv
// Debug Module end of the DMI bus: decodes a small set of DM registers, drives
// halt/resume/ndmreset to the hart and runs abstract register-access commands.
module armleocpu_dmi_target #(
    parameter logic [7:0]  DM_ID      = 8'h00,
    parameter logic [31:0] DATA_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmi_req_valid,
    output logic        dmi_req_ready,
    input  logic        dmi_req_wen,
    input  logic [31:0] dmi_req_wdata,
    input  logic [15:0] dmi_req_addr,
    output logic        dmi_resp_valid,
    input  logic        dmi_resp_ready,
    output logic [31:0] dmi_resp_rdata,
    output logic        dmi_resp_addr_exists,
    output logic        dmi_resp_unknown_error,
    output logic        dbg_haltreq,
    output logic        dbg_resumereq,
    input  logic        dbg_halted,
    output logic        dbg_ndmreset,
    output logic        dbg_cmd_valid,
    input  logic        dbg_cmd_ready,
    output logic        dbg_cmd_write,
    output logic [15:0] dbg_cmd_regno,
    output logic [31:0] dbg_cmd_wdata,
    input  logic        dbg_cmd_done,
    input  logic        dbg_cmd_error,
    input  logic [31:0] dbg_cmd_rdata
);
    typedef enum logic {S_IDLE, S_RESP} dmi_state_t;
    typedef enum logic [1:0] {A_IDLE, A_REQ, A_WAIT} abs_state_t;

    dmi_state_t r_state, w_state_nxt;
    abs_state_t r_abs, w_abs_nxt;

    logic [31:0] r_data0, r_resp_rdata, r_cmd_wdata;
    logic [15:0] r_cmd_regno;
    logic [2:0]  r_cmderr, w_cmderr_nxt;
    logic        r_dmactive, r_haltreq, r_resumereq, r_ndmreset, r_resumeack;
    logic        r_resp_exists, r_cmd_write;

    logic [7:0]  w_off;
    logic [31:0] w_rdata;
    logic        w_exists, w_accept, w_busy, w_abs_done, w_cmd_bad;
    logic        w_wr_data0, w_wr_dmctl, w_wr_acs, w_wr_cmd, w_dm_clear, w_cmd_ok;

    assign w_off      = dmi_req_addr[7:0];
    assign w_accept   = (r_state == S_IDLE) && dmi_req_valid;
    assign w_busy     = (r_abs != A_IDLE);
    assign w_wr_data0 = w_accept && dmi_req_wen && w_exists && (w_off == 8'h04);
    assign w_wr_dmctl = w_accept && dmi_req_wen && w_exists && (w_off == 8'h10);
    assign w_wr_acs   = w_accept && dmi_req_wen && w_exists && (w_off == 8'h16);
    assign w_wr_cmd   = w_accept && dmi_req_wen && w_exists && (w_off == 8'h17);
    assign w_dm_clear = w_wr_dmctl && !dmi_req_wdata[0];
    assign w_cmd_bad  = (dmi_req_wdata[31:24] != 8'h00) || (dmi_req_wdata[22:20] != 3'd2);
    assign w_cmd_ok   = w_wr_cmd && (r_cmderr == 3'd0) && r_dmactive && !w_busy && !w_cmd_bad
                        && dmi_req_wdata[17] && dbg_halted;
    // A done pulse counts in REQ only when it arrives together with ready.
    assign w_abs_done = dbg_cmd_done && ((r_abs == A_WAIT) || ((r_abs == A_REQ) && dbg_cmd_ready));

    always_comb begin
        w_exists = 1'b0;
        w_rdata  = 32'h0;
        if (dmi_req_addr[15:8] == DM_ID) begin
            case (w_off)
                8'h04: begin w_exists = 1'b1; w_rdata = r_data0; end
                8'h10: begin w_exists = 1'b1; w_rdata = {r_haltreq, 29'h0, r_ndmreset, r_dmactive}; end
                8'h11: begin
                    w_exists       = 1'b1;
                    w_rdata        = 32'h0000_0082;
                    w_rdata[9:8]   = {2{dbg_halted}};
                    w_rdata[11:10] = {2{!dbg_halted}};
                    w_rdata[17:16] = {2{r_resumeack}};
                end
                8'h12, 8'h17: w_exists = 1'b1;
                8'h16: begin
                    w_exists      = 1'b1;
                    w_rdata[3:0]  = 4'd1;
                    w_rdata[10:8] = r_cmderr;
                    w_rdata[12]   = w_busy;
                end
                default: ;
            endcase
        end
    end

    // W1C applies first, busy-collision errors next, completion fault last.
    always_comb begin
        w_cmderr_nxt = r_cmderr;
        if (w_wr_acs)
            w_cmderr_nxt = r_cmderr & ~dmi_req_wdata[10:8];
        if ((w_wr_acs || w_wr_data0) && w_busy && (w_cmderr_nxt == 3'd0))
            w_cmderr_nxt = 3'd1;
        if (w_wr_cmd && (r_cmderr == 3'd0) && r_dmactive) begin
            if (w_busy)
                w_cmderr_nxt = 3'd1;
            else if (w_cmd_bad)
                w_cmderr_nxt = 3'd2;
            else if (dmi_req_wdata[17] && !dbg_halted)
                w_cmderr_nxt = 3'd4;
        end
        if (w_abs_done && dbg_cmd_error)
            w_cmderr_nxt = 3'd3;
    end

    always_comb begin
        w_state_nxt    = r_state;
        dmi_req_ready  = (r_state == S_IDLE);
        dmi_resp_valid = (r_state == S_RESP);
        case (r_state)
            S_IDLE: if (dmi_req_valid) w_state_nxt = S_RESP;
            S_RESP: if (dmi_resp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_abs_nxt     = r_abs;
        dbg_cmd_valid = (r_abs == A_REQ);
        case (r_abs)
            A_IDLE: if (w_cmd_ok) w_abs_nxt = A_REQ;
            A_REQ:  if (dbg_cmd_ready) w_abs_nxt = dbg_cmd_done ? A_IDLE : A_WAIT;
            A_WAIT: if (dbg_cmd_done) w_abs_nxt = A_IDLE;
            default: w_abs_nxt = A_IDLE;
        endcase
        if (w_dm_clear)
            w_abs_nxt = A_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_abs   <= A_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_abs   <= w_abs_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_rdata  <= 32'h0;
            r_resp_exists <= 1'b0;
            r_data0       <= DATA_RESET;
            r_dmactive    <= 1'b0;
            r_haltreq     <= 1'b0;
            r_resumereq   <= 1'b0;
            r_ndmreset    <= 1'b0;
            r_resumeack   <= 1'b0;
            r_cmderr      <= 3'd0;
            r_cmd_write   <= 1'b0;
            r_cmd_regno   <= 16'h0;
            r_cmd_wdata   <= 32'h0;
        end else begin
            if (w_accept) begin
                r_resp_rdata  <= dmi_req_wen ? 32'h0 : w_rdata;
                r_resp_exists <= w_exists;
            end
            r_cmderr <= w_cmderr_nxt;
            if (w_abs_done && !dbg_cmd_error && !r_cmd_write)
                r_data0 <= dbg_cmd_rdata;
            else if (w_wr_data0 && !w_busy)
                r_data0 <= dmi_req_wdata;
            if (r_resumereq && !dbg_halted) begin
                r_resumereq <= 1'b0;
                r_resumeack <= 1'b1;
            end
            if (w_wr_dmctl) begin
                if (!r_dmactive) begin
                    r_dmactive <= 1'b1;
                end else begin
                    r_haltreq  <= dmi_req_wdata[31];
                    r_ndmreset <= dmi_req_wdata[1];
                    if (dmi_req_wdata[30] && !dmi_req_wdata[31]) begin
                        r_resumereq <= 1'b1;
                        r_resumeack <= 1'b0;
                    end
                end
            end
            if (w_cmd_ok) begin
                r_cmd_write <= dmi_req_wdata[16];
                r_cmd_regno <= dmi_req_wdata[15:0];
                r_cmd_wdata <= r_data0;
            end
            // dmactive=0 returns every DM register to its reset value.
            if (w_dm_clear) begin
                r_data0     <= DATA_RESET;
                r_dmactive  <= 1'b0;
                r_haltreq   <= 1'b0;
                r_resumereq <= 1'b0;
                r_ndmreset  <= 1'b0;
                r_resumeack <= 1'b0;
                r_cmderr    <= 3'd0;
                r_cmd_write <= 1'b0;
                r_cmd_regno <= 16'h0;
                r_cmd_wdata <= 32'h0;
            end
        end
    end

    assign dmi_resp_rdata         = r_resp_rdata;
    assign dmi_resp_addr_exists   = r_resp_exists;
    assign dmi_resp_unknown_error = 1'b0;
    assign dbg_haltreq            = r_haltreq;
    assign dbg_resumereq          = r_resumereq;
    assign dbg_ndmreset           = r_ndmreset;
    assign dbg_cmd_write          = r_cmd_write;
    assign dbg_cmd_regno          = r_cmd_regno;
    assign dbg_cmd_wdata          = r_cmd_wdata;
endmodule
